// File: rtl/sound_player_if.sv
// Sound interface between the logo dynamics (master) and the tone generator (slave).
// Level-only signals: there is no handshake; the code and mute are sampled every cycle.
interface sound_player_if;
  logic [1:0] code_sound;
  logic       mute;
  logic       speaker;
  logic       busy;

  modport master (
    output code_sound,
    output mute,
    input  speaker,
    input  busy
  );

  modport slave (
    input  code_sound,
    input  mute,
    output speaker,
    output busy
  );
endinterface

// File: rtl/sound_player.sv
// sound_player: plays a fixed-length square-wave burst on each code_sound change. SOUND_QUEUE_EN queues one event instead of preempting.
// busy rises one edge after the change and speaker is registered; there is no backpressure, and a newer pending event overwrites an older one.
module sound_player #(
  parameter int HP_PING = 13636,
  parameter int HP_PONG = 27272,
  parameter int HP_GO   = 9090,
  parameter int HP_STOP = 54545,
  parameter int DUR     = 1200000
) (
  input  logic          clk,
  input  logic          clr,
  sound_player_if.slave snd
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t      state_q, state_d;
  logic [1:0]  code_q, code_d;
  logic [1:0]  cur_q, cur_d;
  logic [15:0] hp_cnt_q, hp_cnt_d;
  logic [23:0] dur_cnt_q, dur_cnt_d;
  logic        tone_q, tone_d;
  logic        speaker_q, speaker_d;
  logic        trig;
  logic        start;
  logic [1:0]  start_code;
`ifdef SOUND_QUEUE_EN
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_code_q, pend_code_d;
`endif

  function automatic logic [15:0] hp_reload(input logic [1:0] c);
    case (c)
      2'd0:    hp_reload = 16'(HP_PING - 1);
      2'd1:    hp_reload = 16'(HP_PONG - 1);
      2'd2:    hp_reload = 16'(HP_GO - 1);
      default: hp_reload = 16'(HP_STOP - 1);
    endcase
  endfunction

  // go/stop are the long sounds: twice the ping/pong duration
  function automatic logic [23:0] dur_reload(input logic [1:0] c);
    dur_reload = c[1] ? 24'(2 * DUR - 1) : 24'(DUR - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      code_q      <= snd.code_sound;
      cur_q       <= 2'd0;
      hp_cnt_q    <= 16'd0;
      dur_cnt_q   <= 24'd0;
      tone_q      <= 1'b0;
      speaker_q   <= 1'b0;
`ifdef SOUND_QUEUE_EN
      pend_v_q    <= 1'b0;
      pend_code_q <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      cur_q       <= cur_d;
      hp_cnt_q    <= hp_cnt_d;
      dur_cnt_q   <= dur_cnt_d;
      tone_q      <= tone_d;
      speaker_q   <= speaker_d;
`ifdef SOUND_QUEUE_EN
      pend_v_q    <= pend_v_d;
      pend_code_q <= pend_code_d;
`endif
    end
  end

  always_comb begin
    trig        = (snd.code_sound != code_q);
    code_d      = snd.code_sound;
    state_d     = state_q;
    cur_d       = cur_q;
    hp_cnt_d    = hp_cnt_q;
    dur_cnt_d   = dur_cnt_q;
    tone_d      = tone_q;
    start       = 1'b0;
    start_code  = snd.code_sound;
`ifdef SOUND_QUEUE_EN
    pend_v_d    = pend_v_q;
    pend_code_d = pend_code_q;
`endif

    case (state_q)
      IDLE: begin
        tone_d = 1'b0;
`ifdef SOUND_QUEUE_EN
        // a fresh change outranks the queued code on the pending-start cycle
        if (trig) begin
          start    = 1'b1;
          pend_v_d = 1'b0;
        end else if (pend_v_q) begin
          start      = 1'b1;
          start_code = pend_code_q;
          pend_v_d   = 1'b0;
        end
`else
        start = trig;
`endif
      end
      PLAY: begin
`ifdef SOUND_QUEUE_EN
        if (trig) begin
          pend_v_d    = 1'b1;
          pend_code_d = snd.code_sound;
        end
`else
        start = trig;
`endif
        if (hp_cnt_q == 16'd0) begin
          tone_d   = ~tone_q;
          hp_cnt_d = hp_reload(cur_q);
        end else begin
          hp_cnt_d = hp_cnt_q - 16'd1;
        end
        if (dur_cnt_q == 24'd0) begin
          state_d = IDLE;
          tone_d  = 1'b0;
        end else begin
          dur_cnt_d = dur_cnt_q - 24'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d   = PLAY;
      cur_d     = start_code;
      hp_cnt_d  = hp_reload(start_code);
      dur_cnt_d = dur_reload(start_code);
      tone_d    = 1'b0;
    end
  end

  assign speaker_d   = tone_q & ~snd.mute;
  assign snd.speaker = speaker_q;
  assign snd.busy    = (state_q == PLAY);

endmodule
